// File: rtl/hex_scan_pkg.sv
// rtl/hex_scan_pkg.sv - shared types, constants and leading-zero helper for hex_scan_ctrl
package hex_scan_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

  localparam logic [7:0] SEG_OFF    = 8'hFF;
  localparam int         MAX_DIGITS = 8;

  // Bit i set means digit i is a leading zero: it and every digit above it
  // hold nibble 0 with no decimal point. Digit 0 is never flagged.
  function automatic logic [MAX_DIGITS-1:0] lz_mask(
    input logic [4*MAX_DIGITS-1:0] data,
    input logic [MAX_DIGITS-1:0]   dp,
    input int                      n
  );
    logic [MAX_DIGITS-1:0] m;
    logic                  zero_above;
    m          = '0;
    zero_above = 1'b1;
    for (int i = MAX_DIGITS - 1; i >= 1; i--) begin
      if (i < n) begin
        zero_above = zero_above && (data[4*i +: 4] == 4'h0) && !dp[i];
        m[i]       = zero_above;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/hex_scan_ctrl_if.sv
// rtl/hex_scan_ctrl_if.sv - valid/ready write port carrying digits, dp and lz enable
// master: host driving wr_valid/wr_data/wr_dp/wr_lz_blank, sampling wr_ready
// slave:  controller accepting the write and driving wr_ready
interface hex_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
) ();

  logic                    wr_valid;
  logic                    wr_ready;
  logic [4*NUM_DIGITS-1:0] wr_data;
  logic [NUM_DIGITS-1:0]   wr_dp;
  logic                    wr_lz_blank;

  modport master (
    output wr_valid, wr_data, wr_dp, wr_lz_blank,
    input  wr_ready
  );

  modport slave (
    input  wr_valid, wr_data, wr_dp, wr_lz_blank,
    output wr_ready
  );

endinterface

// File: rtl/hex_scan_ctrl_hex_driver.sv
// rtl/hex_scan_ctrl_hex_driver.sv - nibble to active-low seven-segment decoder
// nibble_i: hex digit, dp_i: decimal point (active-high)
// seg_o: active-low {dp, g, f, e, d, c, b, a}
module hex_driver (
  input  logic [3:0] nibble_i,
  input  logic       dp_i,
  output logic [7:0] seg_o
);

  logic [6:0] seg7;

  always_comb begin
    seg7 = 7'h7F;
    unique case (nibble_i)
      4'h0: seg7 = 7'h40;
      4'h1: seg7 = 7'h79;
      4'h2: seg7 = 7'h24;
      4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;
      4'h5: seg7 = 7'h12;
      4'h6: seg7 = 7'h02;
      4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;
      4'h9: seg7 = 7'h10;
      4'hA: seg7 = 7'h08;
      4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;
      4'hD: seg7 = 7'h21;
      4'hE: seg7 = 7'h06;
      4'hF: seg7 = 7'h0E;
      default: seg7 = 7'h7F;
    endcase
  end

  assign seg_o = {~dp_i, seg7};

endmodule

// File: rtl/hex_scan_ctrl.sv
// rtl/hex_scan_ctrl.sv - multiplexed seven-segment scanner with frame-aligned shadow commit
// Clk, Reset_n: clock and asynchronous active-low reset
// wr: write port (slave) into the shadow register
// seg_out: registered active-low segments, an_n: registered active-low anodes
// frame_tick: one-cycle pulse in the first cycle of each frame
module hex_scan_ctrl
  import hex_scan_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  hex_scan_ctrl_if.slave        wr,
  output logic [7:0]            seg_out,
  output logic [NUM_DIGITS-1:0] an_n,
  output logic                  frame_tick
);

  localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int IW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DW      = 4 * NUM_DIGITS;

  localparam logic [CW-1:0] DWELL_LAST  = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST  = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST    = IW'(NUM_DIGITS - 1);
  localparam scan_state_t   RESET_STATE = (BLANK_CYCLES == 0) ? SHOW : BLANK;

  scan_state_t           state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  frame_end;

  logic                  pending_q, pending_d;
  logic [DW-1:0]         shadow_data_q, shadow_data_d;
  logic [NUM_DIGITS-1:0] shadow_dp_q, shadow_dp_d;
  logic                  shadow_lz_q, shadow_lz_d;
  logic [DW-1:0]         active_data_q, active_data_d;
  logic [NUM_DIGITS-1:0] active_dp_q, active_dp_d;
  logic                  active_lz_q, active_lz_d;

  logic [7:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_n_q, an_n_d;
  logic                  frame_tick_q, frame_tick_d;

  logic                  accept;
  logic                  commit;
  logic [MAX_DIGITS-1:0] sup_mask;
  logic                  suppress;
  logic [3:0]            nib;
  logic                  dp_bit;
  logic [7:0]            drv_seg;

  // Scan sequencing: one counter serves both states and reloads on every dwell end.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q + 1'b1;
    frame_end = 1'b0;
    unique case (state_q)
      BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = SHOW;
          cnt_d   = '0;
        end
      end
      SHOW: begin
        if (cnt_q == DWELL_LAST) begin
          cnt_d     = '0;
          frame_end = (idx_q == IDX_LAST);
          idx_d     = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
          state_d   = (BLANK_CYCLES == 0) ? SHOW : BLANK;
        end
      end
      default: begin
        state_d = RESET_STATE;
      end
    endcase
  end

  // A write can never coincide with a commit: accept needs pending clear, commit needs it set.
  always_comb begin
    accept        = wr.wr_valid && !pending_q;
    commit        = frame_end && pending_q;
    shadow_data_d = accept ? wr.wr_data     : shadow_data_q;
    shadow_dp_d   = accept ? wr.wr_dp       : shadow_dp_q;
    shadow_lz_d   = accept ? wr.wr_lz_blank : shadow_lz_q;
    pending_d     = accept || (pending_q && !frame_end);
    active_data_d = commit ? shadow_data_q  : active_data_q;
    active_dp_d   = commit ? shadow_dp_q    : active_dp_q;
    active_lz_d   = commit ? shadow_lz_q    : active_lz_q;
  end

  assign wr.wr_ready = ~pending_q;

  // Pins are computed from next-state values so they update on the same edge as
  // the state; this also makes a commit visible immediately when BLANK is absent.
  always_comb begin
    nib    = 4'h0;
    dp_bit = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_d == IW'(i)) begin
        nib    = active_data_d[4*i +: 4];
        dp_bit = active_dp_d[i];
      end
    end
  end

  hex_driver u_hex_driver (
    .nibble_i (nib),
    .dp_i     (dp_bit),
    .seg_o    (drv_seg)
  );

  always_comb begin
    sup_mask     = lz_mask(32'(active_data_d), 8'(active_dp_d), NUM_DIGITS);
    suppress     = active_lz_d && sup_mask[idx_d];
    an_n_d       = '1;
    seg_d        = SEG_OFF;
    frame_tick_d = frame_end;
    if (state_d == SHOW && !suppress) begin
      an_n_d = ~(NUM_DIGITS'(1) << idx_d);
      seg_d  = drv_seg;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q       <= RESET_STATE;
      idx_q         <= '0;
      cnt_q         <= '0;
      pending_q     <= 1'b0;
      shadow_data_q <= '0;
      shadow_dp_q   <= '0;
      shadow_lz_q   <= 1'b0;
      active_data_q <= '0;
      active_dp_q   <= '0;
      active_lz_q   <= 1'b0;
      seg_q         <= SEG_OFF;
      an_n_q        <= '1;
      frame_tick_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      pending_q     <= pending_d;
      shadow_data_q <= shadow_data_d;
      shadow_dp_q   <= shadow_dp_d;
      shadow_lz_q   <= shadow_lz_d;
      active_data_q <= active_data_d;
      active_dp_q   <= active_dp_d;
      active_lz_q   <= active_lz_d;
      seg_q         <= seg_d;
      an_n_q        <= an_n_d;
      frame_tick_q  <= frame_tick_d;
    end
  end

  assign seg_out    = seg_q;
  assign an_n       = an_n_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// tb/tb_hex_scan_ctrl.sv - self-checking bench for hex_scan_ctrl (BLANK=2 and BLANK=0 instances)
module tb_hex_scan_ctrl;

  logic Clk = 1'b0;
  logic Reset_n;
  always #5 Clk = ~Clk;

  hex_scan_ctrl_if #(.NUM_DIGITS(4)) wr1 ();
  hex_scan_ctrl_if #(.NUM_DIGITS(4)) wr2 ();

  logic [7:0] seg1, seg2;
  logic [3:0] an1, an2;
  logic       ft1, ft2;

  hex_scan_ctrl #(.NUM_DIGITS(4), .DWELL_CYCLES(4), .BLANK_CYCLES(2)) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .wr         (wr1.slave),
    .seg_out    (seg1),
    .an_n       (an1),
    .frame_tick (ft1)
  );

  hex_scan_ctrl #(.NUM_DIGITS(4), .DWELL_CYCLES(4), .BLANK_CYCLES(0)) dut_nb (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .wr         (wr2.slave),
    .seg_out    (seg2),
    .an_n       (an2),
    .frame_tick (ft2)
  );

  int checks = 0;
  int errors = 0;
  int k;

  // Reference model: what the display should hold, frame by frame.
  logic [15:0] m_data, s_data;
  logic [3:0]  m_dp, s_dp;
  logic        m_lz, s_lz, m_pending, last_acc;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  function automatic logic suppressed(input int d);
    if (!m_lz || d == 0) return 1'b0;
    for (int j = d; j < 4; j++)
      if (m_data[4*j +: 4] != 4'h0 || m_dp[j]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h (cycle %0d)", tag, obs, exp, k);
    end
  endtask

  task automatic check_pins();
    int s, d, r;
    logic [3:0] ean;
    logic [7:0] eseg;
    s = k % 24; d = s / 6; r = s % 6;
    ean = 4'hF; eseg = 8'hFF;
    if (r >= 2 && !suppressed(d)) begin
      ean  = ~(4'b0001 << d);
      eseg = {~m_dp[d], seg7(m_data[4*d +: 4])};
    end
    chk("an_n", 32'(an1), 32'(ean));
    chk("seg_out", 32'(seg1), 32'(eseg));
    chk("frame_tick", 32'(ft1), 32'(k > 0 && s == 0));
    chk("wr_ready", 32'(wr1.wr_ready), 32'(!m_pending));
    s = k % 16; d = s / 4;
    ean  = (k == 0) ? 4'hF  : ~(4'b0001 << d);
    eseg = (k == 0) ? 8'hFF : 8'hC0;
    chk("nb_an_n", 32'(an2), 32'(ean));
    chk("nb_seg_out", 32'(seg2), 32'(eseg));
    chk("nb_frame_tick", 32'(ft2), 32'(k > 0 && s == 0));
    chk("nb_wr_ready", 32'(wr2.wr_ready), 32'd1);
  endtask

  task automatic tick();
    logic acc;
    acc = wr1.wr_valid && !m_pending;
    @(posedge Clk);
    k++;
    if (k % 24 == 0 && m_pending) begin
      m_data = s_data; m_dp = s_dp; m_lz = s_lz; m_pending = 1'b0;
    end
    if (acc) begin
      s_data = wr1.wr_data; s_dp = wr1.wr_dp; s_lz = wr1.wr_lz_blank; m_pending = 1'b1;
    end
    last_acc = acc;
    #1;
    check_pins();
  endtask

  task automatic tickn(input int n);
    repeat (n) tick();
  endtask

  task automatic goto_frame();
    int n = 0;
    do begin tick(); n++; end while (k % 24 != 0 && n < 30);
  endtask

  task automatic write(input logic [15:0] d, input logic [3:0] p, input logic lz);
    int n = 0;
    wr1.wr_valid = 1'b1; wr1.wr_data = d; wr1.wr_dp = p; wr1.wr_lz_blank = lz;
    do begin tick(); n++; end while (!last_acc && n < 100);
    chk("write_accept_within_bound", 32'(last_acc), 32'd1);
    wr1.wr_valid = 1'b0;
  endtask

  task automatic model_reset();
    k = 0;
    m_data = '0; m_dp = '0; m_lz = 1'b0;
    s_data = '0; s_dp = '0; s_lz = 1'b0;
    m_pending = 1'b0; last_acc = 1'b0;
  endtask

  initial begin
    Reset_n = 1'b0;
    wr1.wr_valid = 1'b0; wr1.wr_data = '0; wr1.wr_dp = '0; wr1.wr_lz_blank = 1'b0;
    wr2.wr_valid = 1'b0; wr2.wr_data = '0; wr2.wr_dp = '0; wr2.wr_lz_blank = 1'b0;
    model_reset();

    repeat (2) @(posedge Clk);
    #1;
    chk("rst_an_n", 32'(an1), 32'hF);
    chk("rst_seg_out", 32'(seg1), 32'hFF);
    chk("rst_frame_tick", 32'(ft1), 32'd0);
    chk("rst_wr_ready", 32'(wr1.wr_ready), 32'd1);
    #5 Reset_n = 1'b1;
    check_pins();

    tickn(2);
    chk("first_show_an", 32'(an1), 32'hE);
    chk("first_show_seg", 32'(seg1), 32'hC0);
    chk("nb_k2_an", 32'(an2), 32'hE);
    tickn(22);
    chk("first_frame_tick", 32'(ft1), 32'd1);
    chk("nb_k24_an", 32'(an2), 32'hB);
    tickn(24);

    tickn(5);
    write(16'h12AF, 4'b0100, 1'b0);
    chk("ready_drop", 32'(wr1.wr_ready), 32'd0);
    goto_frame();
    tickn(2);
    chk("d0_F", 32'(seg1), 32'h8E);
    tickn(6);
    chk("d1_A", 32'(seg1), 32'h88);
    tickn(6);
    chk("d2_2dp", 32'(seg1), 32'h24);
    chk("d2_an", 32'(an1), 32'hB);
    tickn(6);
    chk("d3_1", 32'(seg1), 32'hF9);
    chk("d3_an", 32'(an1), 32'h7);

    tickn(5);
    write(16'hBEEF, 4'b0001, 1'b0);
    write(16'h0C0D, 4'b0000, 1'b0);
    tick();
    chk("first_of_pair_d0", 32'(seg1), 32'h0E);
    goto_frame();
    tickn(2);
    chk("second_of_pair_d0", 32'(seg1), 32'hA1);

    tickn(3);
    write(16'h0030, 4'b0000, 1'b1);
    goto_frame();
    tickn(2);
    chk("lz30_d0_an", 32'(an1), 32'hE);
    chk("lz30_d0_seg", 32'(seg1), 32'hC0);
    tickn(6);
    chk("lz30_d1_an", 32'(an1), 32'hD);
    chk("lz30_d1_seg", 32'(seg1), 32'hB0);
    tickn(6);
    chk("lz30_d2_an", 32'(an1), 32'hF);
    chk("lz30_d2_seg", 32'(seg1), 32'hFF);
    tickn(6);
    chk("lz30_d3_an", 32'(an1), 32'hF);
    tickn(2);
    write(16'h0000, 4'b0000, 1'b1);
    goto_frame();
    tickn(2);
    chk("lz0_d0_seg", 32'(seg1), 32'hC0);
    tickn(6);
    chk("lz0_d1_an", 32'(an1), 32'hF);
    tickn(16);

    for (int i = 0; i < 25; i++) begin
      logic [15:0] d;
      logic [3:0]  p;
      logic        lz;
      tickn($urandom_range(0, 30));
      d  = 16'($urandom_range(0, 65535) >> (4 * $urandom_range(0, 4)));
      p  = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
      lz = 1'($urandom);
      write(d, p, lz);
    end
    goto_frame();
    tickn(24);

    goto_frame();
    tickn(3);
    write(16'h5678, 4'b1111, 1'b0);
    for (int n = 0; n < 30 && (k % 24) != 15; n++) tick();
    chk("pending_before_reset", 32'(wr1.wr_ready), 32'd0);
    chk("digit2_before_reset", 32'(an1), 32'hB);
    #2 Reset_n = 1'b0;
    #1;
    chk("async_rst_an_n", 32'(an1), 32'hF);
    chk("async_rst_seg_out", 32'(seg1), 32'hFF);
    chk("async_rst_frame_tick", 32'(ft1), 32'd0);
    chk("async_rst_wr_ready", 32'(wr1.wr_ready), 32'd1);
    chk("async_rst_nb_an_n", 32'(an2), 32'hF);
    #2 Reset_n = 1'b1;
    model_reset();
    check_pins();
    tickn(8);
    chk("after_rst_d1_an", 32'(an1), 32'hD);
    chk("after_rst_d1_seg", 32'(seg1), 32'hC0);
    tickn(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
